servo_pulse_decoder: RTL and testbench
======================================

# servo_pulse_decoder

Receive-side counterpart of the servo PWM generator. It measures the high time and period of an incoming servo-style pulse train and converts the high time into an R-bit position code on the same scale the generator drives. It sits between an asynchronous servo or feedback pin and the lock status logic. It reports one sample per pulse, plus range-error and signal-loss flags.

## Interface
- CNT_W, 24: width of the high-time and period counters.
- R, 8: position resolution in bits.
- MIN_PULSE, 50_000: high-time count mapping to position 0 (0.5 ms at 100 MHz).
- MAX_PULSE, 250_000: high-time count mapping to full scale (2.5 ms). Must be greater than MIN_PULSE.
- TIMEOUT, 4_000_000: cycles without a rising edge before signal loss is declared. Must be below 2^CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous and active-high.
- pwm_in  in  1  asynchronous pulse input.
- high_cnt  out  CNT_W  high time of the last completed pulse, in cycles.
- period_cnt  out  CNT_W  rising-to-rising period of the last completed pulse, in cycles.
- position  out  R  scaled position of the last sample.
- valid  out  1  one-cycle strobe; all sample outputs update on this cycle.
- err_range  out  1  last sample had high_cnt outside [MIN_PULSE, MAX_PULSE].
- timeout  out  1  signal-loss flag.

## Operation
- Synchronizer: two flops on pwm_in, plus a previous-value flop for edge detection. All three reset to 1, so a line already high at reset release does not produce a false rising edge.
  - rise = sync & ~prev; fall = ~sync & prev.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise, go to HIGH and set hcnt = 1, pcnt = 1.
  - HIGH: hcnt and pcnt increment each cycle. On fall, latch hcnt into h_lat and go to LOW.
  - LOW: pcnt increments each cycle. On rise, publish (h_lat, pcnt), go to HIGH, and reload hcnt = 1, pcnt = 1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Scaling on publish:
  - N = clamp(h_lat - MIN_PULSE, 0, D), where D = MAX_PULSE - MIN_PULSE.
  - err_range_next = (h_lat < MIN_PULSE) | (h_lat > MAX_PULSE).
  - Sequential restoring divider: rem = N. For R iterations: rem <<= 1; if rem >= D, set the quotient bit to 1 and rem -= D. Bits are produced MSB first.
  - Result = floor(N*2^R/D), saturated to 2^R-1. N = D therefore yields all ones.
- Divider busy: if a publish occurs while the divider is busy (period ≤ R cycles), that sample is dropped. Outputs are unchanged and the FSM continues normally.
- Timeout:
  - A separate counter clears on every rise and increments otherwise, saturating.
  - When it reaches TIMEOUT: set timeout = 1 and force the FSM to IDLE.
  - The position, high_cnt and period_cnt outputs hold their last values.
  - The first rise after a timeout starts a fresh measurement with no publish. timeout clears on the next valid.
- Reset mid-pulse: all state is cleared immediately and the FSM goes to IDLE. The partial pulse is never reported.

## Timing
- Reset values:
  - high_cnt = 0, period_cnt = 0, position = 0.
  - valid = 0, err_range = 0, timeout = 0.
  - FSM in IDLE, divider idle, timeout counter 0.
- pwm_in to sync latency: 2 cycles. Measured widths are exact for input pulses synchronous to clk: K cycles high gives high_cnt = K.
- Publish on rise cycle E. The divider runs on cycles E+1 through E+R.
- On cycle E+R+1: valid = 1 for exactly one cycle, and high_cnt, period_cnt, position and err_range update on that same cycle. timeout clears there too.
- The first pulse after reset or timeout produces no valid; the second rising edge produces the first sample.
- If timeout and rise occur on the same cycle, rise wins: the counter clears and no timeout is raised.

## Test plan
All scenarios use MIN_PULSE = 100, MAX_PULSE = 200, TIMEOUT = 1000, R = 8, CNT_W = 16.

- Nominal: 150 cycles high, 350 low, repeated. From the second pulse: valid pulses at rise+9; high_cnt = 150, period_cnt = 500, position = 128, err_range = 0.
- Full scale: high = 200 gives position = 255, err_range = 0. High = 250 gives position = 255, err_range = 1.
- Short pulse: high = 90 gives position = 0, err_range = 1.
- High at reset release: reset released with pwm_in held high; no valid until a real low-to-high transition plus one full period has elapsed.
- Signal loss: pulses stop with the line low.
  - timeout = 1 exactly 1000 cycles after the last rise; position holds.
  - Resumed pulses clear timeout at the first valid, which comes after the second rise.
- Reset mid-operation: assert reset during the high phase. All outputs go to 0 asynchronously, and no valid is reported for the interrupted pulse.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures high time and period of an asynchronous pulse train
// and scales the high time into an R-bit position code with a serial restoring divider.
module servo_pulse_decoder #(
    parameter int CNT_W     = 24,
    parameter int R         = 8,
    parameter int MIN_PULSE = 50_000,
    parameter int MAX_PULSE = 250_000,
    parameter int TIMEOUT   = 4_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [R-1:0]     position,
    output logic             valid,
    output logic             err_range,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] LP_D   = CNT_W'(MAX_PULSE - MIN_PULSE);
    localparam logic [CNT_W:0]   LP_DX  = {1'b0, LP_D};
    localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);
    localparam int               DC_W   = $clog2(R + 1);
    localparam logic [DC_W-1:0]  LP_R   = DC_W'(R);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_offset(input logic [CNT_W-1:0] h);
        if (h < LP_MIN)      return '0;
        else if (h > LP_MAX) return LP_D;
        else                 return h - LP_MIN;
    endfunction

    // Input synchronizer; all flops preset high so a line high at reset gives no rise
    logic r_s1, r_s2, r_prev;
    logic w_rise, w_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= pwm_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_prev;
    assign w_fall = ~r_s2 & r_prev;

    // Signal-loss counter: holds cycles elapsed since the last rise cycle
    logic [CNT_W-1:0] r_tcnt, w_tnext;
    logic             w_tmo_hit;

    assign w_tnext   = w_rise ? CNT_W'(1) : sat_inc(r_tcnt);
    assign w_tmo_hit = ~w_rise & (w_tnext == LP_TMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tcnt <= '0;
        else       r_tcnt <= w_tnext;
    end

    // Measurement FSM
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hcnt, r_pcnt, r_hlat;
    logic             w_publish;

    assign w_publish = (r_state == ST_LOW) & w_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_hlat  <= '0;
        end else if (w_tmo_hit) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rise) begin
                    r_state <= ST_HIGH;
                    r_hcnt  <= CNT_W'(1);
                    r_pcnt  <= CNT_W'(1);
                end
                ST_HIGH: begin
                    r_hcnt <= sat_inc(r_hcnt);
                    r_pcnt <= sat_inc(r_pcnt);
                    if (w_fall) begin
                        r_hlat  <= r_hcnt;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                        r_hcnt  <= CNT_W'(1);
                        r_pcnt  <= CNT_W'(1);
                    end else begin
                        r_pcnt <= sat_inc(r_pcnt);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Serial divider: one quotient bit per cycle, MSB first
    logic             r_busy;
    logic [DC_W-1:0]  r_dcnt;
    logic [CNT_W:0]   r_rem, w_rem2;
    logic [R-1:0]     r_quo, w_quo_next;
    logic [CNT_W-1:0] r_ph, r_pp;
    logic             r_perr, w_qbit, w_last;

    assign w_rem2     = r_rem << 1;
    assign w_qbit     = (w_rem2 >= LP_DX);
    assign w_quo_next = (r_quo << 1) | {{(R-1){1'b0}}, w_qbit};
    assign w_last     = r_busy & (r_dcnt == DC_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_dcnt <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_ph   <= '0;
            r_pp   <= '0;
            r_perr <= 1'b0;
        end else if (w_publish && !r_busy) begin
            r_busy <= 1'b1;
            r_dcnt <= LP_R;
            r_rem  <= {1'b0, clamp_offset(r_hlat)};
            r_quo  <= '0;
            r_ph   <= r_hlat;
            r_pp   <= r_pcnt;
            r_perr <= (r_hlat < LP_MIN) | (r_hlat > LP_MAX);
        end else if (r_busy) begin
            r_rem  <= w_qbit ? (w_rem2 - LP_DX) : w_rem2;
            r_quo  <= w_quo_next;
            r_dcnt <= r_dcnt - 1'b1;
            if (w_last) r_busy <= 1'b0;
        end
    end

    // Output registers: update together with the valid strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            position   <= '0;
            valid      <= 1'b0;
            err_range  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_tmo_hit) timeout <= 1'b1;
            if (w_last) begin
                valid      <= 1'b1;
                high_cnt   <= r_ph;
                period_cnt <= r_pp;
                position   <= w_quo_next;
                err_range  <= r_perr;
                timeout    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: synchronous pulse trains against an arithmetic
// model of the expected samples (cycle, high time, period, position, range flag).
module tb_servo_pulse_decoder;
    localparam int CNT_W = 16;
    localparam int R     = 8;
    localparam int MINP  = 100;
    localparam int MAXP  = 200;
    localparam int TMO   = 1000;
    localparam int LAT   = 2 + R + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic [R-1:0]     position;
    logic             valid, err_range, timeout;

    servo_pulse_decoder #(
        .CNT_W(CNT_W), .R(R), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .position(position),
        .valid(valid), .err_range(err_range), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int h;
        int p;
        int pos;
        int err;
    } samp_t;

    samp_t got_q[$];
    samp_t exp_q[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    have_prev = 0;
    int    prev_hi = 0;
    int    prev_rise = 0;
    int    last_pos = 0;
    int    last_h = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            samp_t s;
            s.c   = cyc;
            s.h   = int'(high_cnt);
            s.p   = int'(period_cnt);
            s.pos = int'(position);
            s.err = int'(err_range);
            got_q.push_back(s);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int ref_pos(input int h);
        int q;
        if (h <= MINP) return 0;
        q = (h - MINP) * (1 << R) / (MAXP - MINP);
        return (q > (1 << R) - 1) ? (1 << R) - 1 : q;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic sample_at(input int n);
        while (cyc < n) tick();
        @(negedge clk);
    endtask

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check_int({tag, "_high_cnt"}, 32'(high_cnt), 0);
        check_int({tag, "_period_cnt"}, 32'(period_cnt), 0);
        check_int({tag, "_position"}, 32'(position), 0);
        check_int({tag, "_valid"}, 32'(valid), 0);
        check_int({tag, "_err_range"}, 32'(err_range), 0);
        check_int({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic check_queue(input string tag);
        check_int({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_int($sformatf("%s[%0d]_cycle", tag, i), got_q[i].c, exp_q[i].c);
            check_int($sformatf("%s[%0d]_high", tag, i), got_q[i].h, exp_q[i].h);
            check_int($sformatf("%s[%0d]_period", tag, i), got_q[i].p, exp_q[i].p);
            check_int($sformatf("%s[%0d]_pos", tag, i), got_q[i].pos, exp_q[i].pos);
            check_int($sformatf("%s[%0d]_err", tag, i), got_q[i].err, exp_q[i].err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // A rising edge on pwm_in at the current cycle publishes the previous pulse
    task automatic start_pulse(input int hi);
        samp_t s;
        if (have_prev != 0) begin
            s.c   = cyc + LAT;
            s.h   = prev_hi;
            s.p   = cyc - prev_rise;
            s.pos = ref_pos(prev_hi);
            s.err = (prev_hi < MINP || prev_hi > MAXP) ? 1 : 0;
            exp_q.push_back(s);
            last_pos = s.pos;
            last_h   = s.h;
        end
        prev_hi   = hi;
        prev_rise = cyc;
        have_prev = 1;
        pwm_in    = 1'b1;
    endtask

    task automatic send(input int hi, input int lo);
        tick();
        start_pulse(hi);
        repeat (hi) tick();
        pwm_in = 1'b0;
        repeat (lo - 1) tick();
    endtask

    initial begin
        int rlast;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        reset = 1'b0;
        repeat (20) tick();

        // Nominal train, then randomized widths, then range boundaries
        repeat (4) send(150, 350);
        @(negedge clk);
        check_int("nominal_position", 32'(position), 128);
        check_int("nominal_high_cnt", 32'(high_cnt), 150);
        check_int("nominal_period_cnt", 32'(period_cnt), 500);
        check_int("nominal_err_range", 32'(err_range), 0);
        for (int i = 0; i < 10; i++) send($urandom_range(80, 230), $urandom_range(20, 400));
        send(200, 300);
        send(250, 250);
        send(90, 400);
        send(100, 300);
        send(150, 350);

        // Signal loss after a final pulse that is never published
        tick();
        start_pulse(150);
        rlast = cyc;
        repeat (150) tick();
        pwm_in = 1'b0;
        sample_at(rlast + 2 + TMO - 1);
        check_int("loss_timeout_early", 32'(timeout), 0);
        sample_at(rlast + 2 + TMO);
        check_int("loss_timeout_set", 32'(timeout), 1);
        check_int("loss_position_hold", 32'(position), last_pos);
        check_int("loss_high_hold", 32'(high_cnt), last_h);
        check_queue("train");

        have_prev = 0;
        send(120, 380);
        @(negedge clk);
        check_int("resume_timeout_still_set", 32'(timeout), 1);
        send(120, 380);
        send(180, 320);
        @(negedge clk);
        check_int("resume_timeout_cleared", 32'(timeout), 0);
        check_queue("resume");

        // Reset asserted in the middle of a high phase
        send(150, 350);
        send(150, 350);
        tick();
        start_pulse(150);
        repeat (70) tick();
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        check_queue("pre_midreset");
        pwm_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        have_prev = 0;
        repeat (300) tick();
        @(negedge clk);
        check_int("midreset_no_valid", got_q.size(), 0);
        check_zero("after_midreset");

        // Reset released while the line is high
        tick();
        reset  = 1'b1;
        pwm_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (60) tick();
        pwm_in = 1'b0;
        repeat (200) tick();
        have_prev = 0;
        send(130, 370);
        send(130, 370);
        send(160, 340);
        @(negedge clk);
        check_queue("high_at_release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
